// File: rtl/inst_sequencer_pkg.sv
// Shared instruction-format constants for the instruction sequencer.
package inst_sequencer_pkg;

    localparam int INST_WIDTH = 64;
    localparam int OPC_LSB    = 24;
    localparam int OPC_MSB    = 26;
    localparam int OPC_WIDTH  = OPC_MSB - OPC_LSB + 1;
    localparam int WB_SEL_BIT = 63;

    // Any non-zero opcode produces a result; opcode 0 is a load.
    function automatic logic is_compute(input logic [OPC_WIDTH-1:0] opc);
        return opc != '0;
    endfunction

endpackage

// File: rtl/inst_buffer.sv
// Program buffer: one write port, one registered read port.
// The storage array has no reset so it maps onto distributed RAM; only the
// read register is reset so the instruction output starts at zero.
module inst_buffer
    import inst_sequencer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [$clog2(DEPTH)-1:0]     waddr_i,
    input  logic [INST_WIDTH-1:0]        wdata_i,
    input  logic                         re_i,
    input  logic [$clog2(DEPTH)-1:0]     raddr_i,
    output logic [INST_WIDTH-1:0]        rdata_o
);

    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic [INST_WIDTH-1:0] rdata_q;

    // Storage write, no reset so contents survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register advances only on an issue, so the word is held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: replays a stored program loop_cnt times toward the
// PE control decoder and tracks outstanding results until they all return.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PEND_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [INST_WIDTH-1:0]        wr_data,
    input  logic                         start,
    input  logic [$clog2(DEPTH):0]       prog_len,
    input  logic [7:0]                   loop_cnt,
    input  logic                         stall,
    input  logic                         result_v,
    output logic                         inst_v,
    output logic [INST_WIDTH-1:0]        inst,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         pc_q, pc_d;
    logic [AW-1:0]         last_q, last_d;
    logic [7:0]            pass_q, pass_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  err_q, err_d;
    logic                  inst_v_q;
    logic                  issue;
    logic                  len_ok;
    logic                  cmp_iss;

    assign len_ok  = (prog_len != '0) && (prog_len <= LW'(DEPTH));
    // A compute instruction counts as issued when it appears on the output.
    assign cmp_iss = inst_v_q && is_compute(inst[OPC_MSB:OPC_LSB]);

    inst_buffer #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en && (state_q == S_IDLE)),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (issue),
        .raddr_i (pc_q),
        .rdata_o (inst)
    );

    // Next-state, program counter, pass counter and outstanding-result logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        pass_d  = pass_q;
        pend_d  = pend_q;
        err_d   = err_q;
        issue   = 1'b0;

        if (cmp_iss && !result_v) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + PEND_WIDTH'(1);
            end
        end else if (!cmp_iss && result_v) begin
            if (pend_q == '0) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q - PEND_WIDTH'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && len_ok) begin
                    state_d = S_ISSUE;
                    pc_d    = '0;
                    last_d  = AW'(prog_len - LW'(1));
                    pass_d  = (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
                    pend_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (pc_q == last_q) begin
                        pc_d   = '0;
                        pass_d = pass_q - 8'd1;
                        if (pass_q == 8'd1) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // The last issued word is still on the output until inst_v drops.
                if ((pend_q == '0) && !inst_v_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            last_q   <= '0;
            pass_q   <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
            inst_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
            pass_q   <= pass_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            inst_v_q <= issue;
        end
    end

    assign inst_v = inst_v_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed corner sequences, a table
// of start vectors, and randomized runs checked against a sequence model.
module tb_inst_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          start;
    logic [AW:0]   prog_len;
    logic [7:0]    loop_cnt;
    logic          stall;
    logic          result_v;
    logic          inst_v;
    logic [63:0]   inst;
    logic          busy;
    logic          done;
    logic          err;

    inst_sequencer #(.DEPTH(DEPTH), .PEND_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .prog_len(prog_len),
        .loop_cnt(loop_cnt), .stall(stall), .result_v(result_v),
        .inst_v(inst_v), .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem_m [DEPTH];
    logic [63:0] obs_q [$];
    int done_cnt  = 0;
    int comp_seen = 0;
    int res_given = 0;

    typedef struct {
        int len;
        int loops;
        bit exp_busy;
        int exp_iss;
    } vec_t;
    vec_t tbl [8];

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (inst_v) begin
            obs_q.push_back(inst);
            if (inst[26:24] != 3'd0) comp_seen++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_word(input int opc);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[26:24] = opc[2:0];
        return w;
    endfunction

    task automatic load(input int a, input logic [63:0] w);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = w;
        tick();
        wr_en   = 1'b0;
        mem_m[a] = w;
    endtask

    task automatic wait_idle(input string nm, input int budget, input int res_pct);
        int n = 0;
        while (busy && n < budget) begin
            result_v = (comp_seen > res_given) && (int'($urandom_range(99)) < res_pct);
            if (result_v) res_given++;
            tick();
            n++;
        end
        result_v = 1'b0;
        check({nm, " idle"}, 64'(busy), 64'(0));
    endtask

    // Runs one program with random stalls/returns; model: the issued stream is
    // mem[0..len-1] repeated max(loops,1) times, or nothing if len is illegal.
    task automatic run_prog(input string nm, input int len, input int loops,
                            input int stall_pct, input int res_pct, input bit exp_busy,
                            input int exp_iss);
        logic [63:0] exp_q [$];
        int ob, db, n_iss, mism, passes;
        bit acc;
        ob = obs_q.size();
        db = done_cnt;
        res_given = comp_seen;
        prog_len = len[AW:0];
        loop_cnt = loops[7:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = busy;
        wait_idle(nm, 3000, res_pct);
        passes = (loops == 0) ? 1 : loops;
        if (len >= 1 && len <= DEPTH) begin
            for (int p = 0; p < passes; p++)
                for (int i = 0; i < len; i++) exp_q.push_back(mem_m[i]);
        end
        n_iss = obs_q.size() - ob;
        mism = 0;
        if (n_iss == exp_q.size()) begin
            for (int i = 0; i < n_iss; i++)
                if (obs_q[ob + i] !== exp_q[i]) mism++;
        end else begin
            mism = 1;
        end
        check({nm, " accepted"}, 64'(acc), 64'(exp_busy));
        check({nm, " issues"}, 64'(n_iss), 64'(exp_iss));
        check({nm, " sequence"}, 64'(mism), 64'(0));
        check({nm, " done"}, 64'(done_cnt - db), exp_busy ? 64'(1) : 64'(0));
        check({nm, " err"}, 64'(err), 64'(0));
    endtask

    // Random stall wrapper used by the run loop.
    always @(posedge clk) begin
        #2;
        if (busy && rand_stall_pct > 0)
            stall = (int'($urandom_range(99)) < rand_stall_pct);
        else if (rand_stall_pct > 0)
            stall = 1'b0;
    end
    int rand_stall_pct = 0;

    initial begin
        int db;
        int exp_v [7];
        int exp_i [7];
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        prog_len = '0; loop_cnt = '0; stall = 1'b0; result_v = 1'b0;
        tick(); tick();
        check("reset inst_v", 64'(inst_v), 64'(0));
        check("reset inst", inst, 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset err", 64'(err), 64'(0));
        rst_n = 1'b1;
        tick();

        // Four words with opcodes 1,2,3,0, single pass, no stall.
        load(0, mk_word(1)); load(1, mk_word(2)); load(2, mk_word(3)); load(3, mk_word(0));
        db = done_cnt;
        prog_len = 5'd4; loop_cnt = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("first cycle inst_v", 64'(inst_v), 64'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("basic inst_v", 64'(inst_v), 64'(1));
            check("basic word", inst, mem_m[k]);
        end
        tick();
        check("basic end inst_v", 64'(inst_v), 64'(0));
        check("basic drain busy", 64'(busy), 64'(1));
        wr_en = 1'b1; wr_addr = '0; wr_data = ~mem_m[0]; result_v = 1'b1;
        tick();
        wr_en = 1'b0;
        tick(); tick();
        result_v = 1'b0;
        res_given = comp_seen;
        wait_idle("basic", 20, 0);
        check("basic done count", 64'(done_cnt - db), 64'(1));
        check("basic err", 64'(err), 64'(0));

        // Stall on the second issue cycle for three cycles.
        exp_v = '{1, 0, 0, 0, 1, 1, 1};
        exp_i = '{0, 0, 0, 0, 1, 2, 3};
        db = done_cnt;
        res_given = comp_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            check("stall inst_v", 64'(inst_v), 64'(exp_v[c-2]));
            check("stall word", inst, mem_m[exp_i[c-2]]);
            stall = (c <= 4);
        end
        stall = 1'b0;
        tick();
        check("stall end inst_v", 64'(inst_v), 64'(0));
        wait_idle("stall", 20, 100);
        check("stall done count", 64'(done_cnt - db), 64'(1));

        // Result coincident with a compute issue, then an unmatched result.
        load(0, mk_word(1));
        db = done_cnt;
        prog_len = 5'd1; loop_cnt = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("coinc inst_v", 64'(inst_v), 64'(1));
        result_v = 1'b1;
        tick();
        result_v = 1'b0;
        check("coinc err", 64'(err), 64'(0));
        res_given = comp_seen;
        wait_idle("coinc", 10, 0);
        check("coinc done count", 64'(done_cnt - db), 64'(1));
        result_v = 1'b1;
        tick();
        result_v = 1'b0;
        check("extra result err", 64'(err), 64'(1));
        tick(); tick(); tick();
        check("err sticky", 64'(err), 64'(1));
        prog_len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("len0 busy", 64'(busy), 64'(0));
        check("err kept on rejected start", 64'(err), 64'(1));
        res_given = comp_seen;
        prog_len = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("restart busy", 64'(busy), 64'(1));
        check("err cleared by start", 64'(err), 64'(0));
        wait_idle("restart", 20, 100);

        // Asynchronous reset in the middle of issuing.
        prog_len = 5'd4; loop_cnt = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        db = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("async rst inst_v", 64'(inst_v), 64'(0));
        check("async rst inst", inst, 64'(0));
        check("async rst busy", 64'(busy), 64'(0));
        check("async rst done", 64'(done), 64'(0));
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("abort no done", 64'(done_cnt - db), 64'(0));
        prog_len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("post-reset len0 busy", 64'(busy), 64'(0));
        tick();
        check("post-reset len0 busy later", 64'(busy), 64'(0));

        // Buffer kept across reset and write while busy was dropped.
        run_prog("retain", 4, 1, 0, 100, 1'b1, 4);

        // Table of start vectors over a random program, with random stalls.
        for (int a = 0; a < DEPTH; a++) load(a, mk_word(($urandom_range(1) == 0) ? 0 : int'($urandom_range(7))));
        tbl[0] = '{len: 4,  loops: 1, exp_busy: 1'b1, exp_iss: 4};
        tbl[1] = '{len: 3,  loops: 2, exp_busy: 1'b1, exp_iss: 6};
        tbl[2] = '{len: 16, loops: 1, exp_busy: 1'b1, exp_iss: 16};
        tbl[3] = '{len: 5,  loops: 0, exp_busy: 1'b1, exp_iss: 5};
        tbl[4] = '{len: 0,  loops: 3, exp_busy: 1'b0, exp_iss: 0};
        tbl[5] = '{len: 17, loops: 1, exp_busy: 1'b0, exp_iss: 0};
        tbl[6] = '{len: 1,  loops: 3, exp_busy: 1'b1, exp_iss: 3};
        tbl[7] = '{len: 2,  loops: 2, exp_busy: 1'b1, exp_iss: 4};
        rand_stall_pct = 25;
        for (int t = 0; t < 8; t++) begin
            run_prog($sformatf("tbl%0d", t), tbl[t].len, tbl[t].loops, 25, 40,
                     tbl[t].exp_busy, tbl[t].exp_iss);
        end

        // Fully random runs.
        for (int r = 0; r < 6; r++) begin
            int len, loops;
            len   = int'($urandom_range(1, 16));
            loops = int'($urandom_range(0, 3));
            load(int'($urandom_range(15)), mk_word(int'($urandom_range(7))));
            run_prog($sformatf("rand%0d", r), len, loops, 25, 50, 1'b1,
                     len * ((loops == 0) ? 1 : loops));
        end
        rand_stall_pct = 0;
        stall = 1'b0;
        tick();

        // Outstanding-result counter saturates at 1023.
        for (int a = 0; a < DEPTH; a++) load(a, mk_word(1 + int'($urandom_range(6))));
        db = done_cnt;
        prog_len = 5'd16; loop_cnt = 8'd64; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1034; c++) tick();
        check("sat still busy", 64'(busy), 64'(1));
        result_v = 1'b1;
        for (int c = 0; c < 1022; c++) tick();
        result_v = 1'b0;
        tick(); tick(); tick();
        check("sat busy after 1022", 64'(busy), 64'(1));
        result_v = 1'b1;
        tick();
        result_v = 1'b0;
        wait_idle("sat", 10, 0);
        check("sat done count", 64'(done_cnt - db), 64'(1));
        check("sat err", 64'(err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
